// File: rtl/sram_arb_pkg.sv
// Shared constants and request type for the two-port SRAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sram_arb_pkg;

  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 32;
  // Request accept to rsp_valid, in cycles.
  localparam int RD_LATENCY  = 2;

  typedef struct packed {
    logic                   we;
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
  } sram_req_t;

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way grant generator: round-robin or fixed priority (requester 0 wins).
// Latency: grant is combinational from req; the mode bit and last_grant are registered.
// Backpressure: grants only valid requesters, at most one per cycle, none while rst=1.
//
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   req       per-requester valid
//   rr_en     arbitration mode, registered every cycle (1 = round-robin)
//   accept    a handshake completed this cycle; advances last_grant
//   grant     one-hot grant
module sram_arb_rr2 #(
  parameter bit RR_EN_DEFAULT = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       rr_en,
  input  logic       accept,
  output logic [1:0] grant
);

  // last_grant = 1 means requester 1 won the previous handshake.
  // Resetting it to 1 lets requester 0 win the first tie.
  logic last_grant;
  logic rr_mode;

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
      rr_mode    <= RR_EN_DEFAULT;
    end else begin
      rr_mode <= rr_en;
      if (accept) begin
        last_grant <= grant[1];
      end
    end
  end

  always_comb begin
    grant = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        // Tie: in round-robin mode hand it to whoever did not win last.
        2'b11:   grant = (rr_mode && !last_grant) ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM macro between two valid/ready requesters; the macro is driven from registers.
// Latency: read accept to rsp_valid pulse = 2 cycles; writes produce no response; one accept per cycle.
// Backpressure: req_ready is the grant; the response channel is valid-only and cannot be stalled.
//
// Ports:
//   clk, rst               clock shared with the macro, synchronous active-high reset
//   req_valid/req_ready    per-requester handshake; req_we/req_addr/req_wdata packed per requester
//   rsp_valid, rsp_rdata   one-cycle read-data pulse tagged by requester, shared data bus
//   rr_en                  arbitration mode (1 = round-robin, 0 = requester 0 fixed priority)
//   sram_we/wmask/addr/din registered macro inputs; sram_dout macro read data
//   collision_cnt          saturating count of cycles with both requesters valid
//                          (present only when SRAM_ARB_COLLISION_CNT_EN is defined)
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH    = SRAM_ADDR_W,
  parameter int DATA_WIDTH    = SRAM_DATA_W,
  parameter int NUM_REQ       = 2,
  parameter bit RR_EN_DEFAULT = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  input  logic                          rr_en,
  output logic                          sram_we,
  output logic                          sram_wmask,
  output logic [ADDR_WIDTH-1:0]         sram_addr,
  output logic [DATA_WIDTH-1:0]         sram_din,
  input  logic [DATA_WIDTH-1:0]         sram_dout
`ifdef SRAM_ARB_COLLISION_CNT_EN
  ,
  output logic [15:0]                   collision_cnt
`endif
);

  logic [1:0] grant;
  logic       accept;
  logic       gnt_id;
  sram_req_t  sel;

  sram_arb_rr2 #(
    .RR_EN_DEFAULT(RR_EN_DEFAULT)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid),
    .rr_en (rr_en),
    .accept(accept),
    .grant (grant)
  );

  assign req_ready = grant;
  assign accept    = |(req_valid & grant);
  assign gnt_id    = grant[1];

  always_comb begin
    sel.we    = gnt_id ? req_we[1] : req_we[0];
    sel.addr  = gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    sel.wdata = gnt_id ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
  end

  // Read tracking shift: bit 0 is loaded at the accept edge, the macro samples
  // the registered request one edge later, and the last stage marks the edge
  // where sram_dout holds the read result.
  logic [RD_LATENCY-1:0] rd_pipe;
  logic [RD_LATENCY-1:0] id_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_we    <= 1'b0;
      sram_wmask <= 1'b0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rd_pipe    <= '0;
      id_pipe    <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
    end else begin
      rd_pipe <= {rd_pipe[RD_LATENCY-2:0], accept & ~sel.we};
      id_pipe <= {id_pipe[RD_LATENCY-2:0], gnt_id};

      if (accept) begin
        sram_we    <= sel.we;
        sram_wmask <= sel.we;
        sram_addr  <= sel.addr;
        sram_din   <= sel.wdata;
      end else begin
        // Idle: address and data hold, so the macro performs a discarded read.
        sram_we    <= 1'b0;
        sram_wmask <= 1'b0;
      end

      rsp_valid <= {NUM_REQ{rd_pipe[RD_LATENCY-1]}} &
                   {id_pipe[RD_LATENCY-1], ~id_pipe[RD_LATENCY-1]};
      if (rd_pipe[RD_LATENCY-1]) begin
        rsp_rdata <= sram_dout;
      end
    end
  end

`ifdef SRAM_ARB_COLLISION_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_cnt <= '0;
    end else if ((&req_valid) && (collision_cnt != 16'hFFFF)) begin
      collision_cnt <= collision_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM macro
// and a transaction-level reference model (memory map + response queue).
module tb_sram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [DW-1:0] rsp_rdata;
  logic          rr_en;
  logic          sram_we, sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din, sram_dout;
`ifdef SRAM_ARB_COLLISION_CNT_EN
  logic [15:0]   collision_cnt;
`endif

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rr_en     (rr_en),
    .sram_we   (sram_we),
    .sram_wmask(sram_wmask),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_dout (sram_dout)
`ifdef SRAM_ARB_COLLISION_CNT_EN
    ,
    .collision_cnt(collision_cnt)
`endif
  );

  // Behavioural 512x32 single-port macro: dout is garbage after a write.
  logic [DW-1:0] mac_mem [512];
  always @(posedge clk) begin
    if (sram_we) begin
      if (sram_wmask) mac_mem[sram_addr] <= sram_din;
      sram_dout <= $urandom;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    int            id;
    bit            known;
    logic [DW-1:0] data;
  } rsp_t;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            cyc = 0;
  int            m_last_id = 1;
  bit            m_mode = 1'b1;
  logic          m_we = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_din = '0;
  bit            m_just_rst = 1'b1;
  int            m_coll = 0;
  rsp_t          rq[$];
  logic [DW-1:0] ref_mem [int];

  // stimulus: held request per requester
  bit            rv [2];
  bit            rwe[2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rdat[2];

  // observations
  int            last_acc_cyc, last_rsp_cyc, last_rsp_id;
  logic [DW-1:0] last_rsp_data;
  int            n_rsp0 = 0, n_rsp1 = 0, n_ready1 = 0;
  int            gnt_hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      if (n_bad <= 50) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: drive held requests, check outputs at negedge, advance model at posedge.
  task automatic tick(output int g);
    rsp_t       e;
    logic [1:0] exp_v;
    req_valid = {rv[1], rv[0]};
    req_we    = {rwe[1], rwe[0]};
    req_addr  = {raddr[1], raddr[0]};
    req_wdata = {rdat[1], rdat[0]};
    @(negedge clk);
    g = -1;
    if (!rst) begin
      if (rv[0] && rv[1]) g = m_mode ? 1 - m_last_id : 0;
      else if (rv[0])     g = 0;
      else if (rv[1])     g = 1;
    end
    check("req_ready", req_ready, (g < 0) ? 2'b00 : 2'(1 << g));
    exp_v = 2'b00;
    e.known = 1'b0;
    if (rq.size() != 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      exp_v = 2'(1 << e.id);
    end
    check("rsp_valid", rsp_valid, exp_v);
    if (exp_v != 0 && e.known) check("rsp_rdata", rsp_rdata, e.data);
    if (m_just_rst) check("rsp_rdata_rst", rsp_rdata, 0);
    if (rsp_valid[0]) n_rsp0++;
    if (rsp_valid[1]) n_rsp1++;
    if (req_ready[1]) n_ready1++;
    if (rsp_valid != 0) begin
      last_rsp_cyc  = cyc;
      last_rsp_id   = rsp_valid[1] ? 1 : 0;
      last_rsp_data = rsp_rdata;
    end
    check("sram_we", sram_we, m_we);
    check("sram_wmask", sram_wmask, m_we);
    check("sram_addr", sram_addr, m_addr);
    check("sram_din", sram_din, m_din);
`ifdef SRAM_ARB_COLLISION_CNT_EN
    check("collision_cnt", collision_cnt, m_coll);
`endif
    @(posedge clk);
    cyc++;
    if (rst) begin
      rq.delete();
      m_last_id = 1; m_mode = 1'b1;
      m_we = 1'b0; m_addr = '0; m_din = '0;
      m_just_rst = 1'b1; m_coll = 0;
    end else begin
      m_just_rst = 1'b0;
      if (rv[0] && rv[1] && m_coll < 65535) m_coll++;
      m_mode = rr_en;
      if (g >= 0) begin
        m_last_id = g;
        m_we = rwe[g]; m_addr = raddr[g]; m_din = rdat[g];
        last_acc_cyc = cyc;
        gnt_hist.push_back(g);
        if (rwe[g]) ref_mem[int'(raddr[g])] = rdat[g];
        else begin
          e.due = cyc + 2; e.id = g;
          e.known = ref_mem.exists(int'(raddr[g]));
          e.data = e.known ? ref_mem[int'(raddr[g])] : '0;
          rq.push_back(e);
        end
      end else begin
        m_we = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    int g;
    for (int k = 0; k < n; k++) tick(g);
  endtask

  task automatic do_reset(input bit mode);
    rr_en = mode;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic do_req(input int id, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int g;
    bit done;
    done = 1'b0;
    rv[id] = 1'b1; rwe[id] = we; raddr[id] = a; rdat[id] = d;
    for (int k = 0; k < 20 && !done; k++) begin
      tick(g);
      if (g == id) done = 1'b1;
    end
    rv[id] = 1'b0;
    check("req_accepted", done, 1);
  endtask

  task automatic hold_both_reads(input int n, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    int g;
    rwe[0] = 1'b0; rwe[1] = 1'b0; raddr[0] = a0; raddr[1] = a1;
    for (int k = 0; k < n; k++) begin
      rv[0] = 1'b1; rv[1] = 1'b1;
      tick(g);
    end
    rv[0] = 1'b0; rv[1] = 1'b0;
  endtask

  function automatic logic [AW-1:0] pick_addr();
    case ($urandom_range(0, 5))
      0: return 9'h000;
      1: return 9'h001;
      2: return 9'h002;
      3: return 9'h1FF;
      4: return 9'h1FE;
      default: return AW'($urandom);
    endcase
  endfunction

  int acc, snap, snap1;

  initial begin
    rst = 1'b1; rr_en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rdat[i] = '0;
    end
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;

    // Reset state
    do_reset(1'b1);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_sram_addr", sram_addr, 0);

    // Write then read back on requester 0
    snap1 = n_rsp1;
    do_req(0, 1'b1, 9'h005, 32'hDEADBEEF);
    idle(2);
    do_req(0, 1'b0, 9'h005, 32'h0);
    acc = last_acc_cyc;
    idle(4);
    check("t1_latency", last_rsp_cyc - acc, 2);
    check("t1_data", last_rsp_data, 32'hDEADBEEF);
    check("t1_id", last_rsp_id, 0);
    check("t1_no_rsp1", n_rsp1 - snap1, 0);

    // Round-robin alternation
    do_req(0, 1'b1, 9'h010, 32'hA0A0A0A0);
    do_req(1, 1'b1, 9'h011, 32'hA1A1A1A1);
    do_reset(1'b1);
    gnt_hist.delete();
    snap = n_rsp0; snap1 = n_rsp1;
    hold_both_reads(6, 9'h010, 9'h011);
    idle(4);
    check("t2_n_grants", gnt_hist.size(), 6);
    for (int k = 0; k < 6 && k < gnt_hist.size(); k++) check("t2_grant_seq", gnt_hist[k], k % 2);
    check("t2_rsp0", n_rsp0 - snap, 3);
    check("t2_rsp1", n_rsp1 - snap1, 3);

    // Fixed priority
    do_reset(1'b0);
    gnt_hist.delete();
    snap = n_ready1;
    hold_both_reads(6, 9'h010, 9'h011);
    idle(4);
    check("t3_n_grants", gnt_hist.size(), 6);
    for (int k = 0; k < gnt_hist.size(); k++) check("t3_grant_fixed", gnt_hist[k], 0);
    check("t3_no_ready1", n_ready1 - snap, 0);

    // Requester 1 read-after-write at the top address, then wrap/aliasing
    rr_en = 1'b1;
    do_req(1, 1'b1, 9'h1FF, 32'h1);
    acc = last_acc_cyc;
    do_req(1, 1'b0, 9'h1FF, 32'h0);
    check("t4_back_to_back", last_acc_cyc - acc, 1);
    idle(4);
    check("t4_raw_cycle", last_rsp_cyc - acc, 3);
    check("t4_raw_data", last_rsp_data, 32'h1);
    check("t4_raw_id", last_rsp_id, 1);
    do_req(1, 1'b1, 9'h000, 32'hAAAA0000);
    do_req(1, 1'b1, 9'h1FF, 32'h5555FFFF);
    do_req(1, 1'b0, 9'h000, 32'h0);
    idle(3);
    check("t4_wrap_lo", last_rsp_data, 32'hAAAA0000);
    do_req(1, 1'b0, 9'h1FF, 32'h0);
    idle(3);
    check("t4_wrap_hi", last_rsp_data, 32'h5555FFFF);

    // Reset while a read is in flight
    do_req(0, 1'b1, 9'h007, 32'h0BADF00D);
    idle(2);
    do_req(0, 1'b0, 9'h007, 32'h0);
    snap = n_rsp0 + n_rsp1;
    rst = 1'b1;
    idle(1);
    check("t5_sram_we", sram_we, 0);
    check("t5_sram_wmask", sram_wmask, 0);
    check("t5_sram_addr", sram_addr, 0);
    check("t5_sram_din", sram_din, 0);
    rst = 1'b0;
    idle(4);
    check("t5_dropped", n_rsp0 + n_rsp1 - snap, 0);
    do_req(0, 1'b0, 9'h007, 32'h0);
    idle(3);
    check("t5_mem_kept", last_rsp_data, 32'h0BADF00D);

    // Randomized traffic: held requests, random mode flips and occasional resets
    for (int n = 0; n < 3000; n++) begin
      int g;
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] && $urandom_range(0, 99) < 60) begin
          rv[i] = 1'b1;
          rwe[i] = ($urandom_range(0, 99) < 45);
          raddr[i] = pick_addr();
          rdat[i] = $urandom;
        end
      end
      if ($urandom_range(0, 99) < 8) rr_en = ~rr_en;
      rst = ($urandom_range(0, 199) == 0);
      tick(g);
      if (g >= 0) rv[g] = 1'b0;
    end
    rst = 1'b0; rv[0] = 1'b0; rv[1] = 1'b0;
    idle(4);

`ifdef SRAM_ARB_COLLISION_CNT_EN
    do_reset(1'b1);
    hold_both_reads(10, 9'h010, 9'h011);
    check("coll_10", collision_cnt, 10);
    hold_both_reads(65540, 9'h010, 9'h011);
    check("coll_sat", collision_cnt, 16'hFFFF);
    idle(4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
